instr_decode_issue: RTL and testbench
=====================================

# instr_decode_issue

Upstream neighbour of the Processor execute stage. Accepts 32-bit instruction words over a valid/ready handshake, buffers them in a small FIFO, reads operands from an 8-entry register file, and issues one decoded instruction per cycle as `enable_ex`/`src1`/`src2`/`imm`/`control_out`. A write-pending scoreboard stalls issue on read-after-write hazards until the execute stage's result returns on the writeback port.

## Interface
- `DATA_W`, 32: operand, immediate and writeback width.
- `REG_AW`, 3: register address width; 2**REG_AW registers, r0 reads as zero.
- `FIFO_DEPTH`, 4: instruction buffer entries; power of two, at least 2.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-low.
- `instr_valid` in 1: `instr` holds a valid word.
- `instr_ready` out 1: the FIFO can accept a word.
- `instr` in 32: instruction word.
- `stall_in` in 1: execute stage cannot take an issue this cycle.
- `wb_en` in 1: writeback strobe.
- `wb_addr` in REG_AW: writeback destination.
- `wb_data` in DATA_W: writeback value, taken from the execute stage's `aluout`.
- `enable_ex` out 1: one-cycle pulse per issued instruction.
- `src1` out DATA_W: rs1 operand.
- `src2` out DATA_W: rs2 operand.
- `imm` out DATA_W: sign-extended imm16.
- `control_out` out 7: {rd[2:0], opcode[3:0]}; drives the execute stage's `control_in`.
- `busy` out 1: FIFO non-empty or any scoreboard bit set.

## Operation
- Instruction fields: [31:28] opcode, [27:25] rd, [24:22] rs1, [21:19] rs2, [18:16] reserved (ignored), [15:0] imm16.
- A word is accepted when `instr_valid && instr_ready`. `instr_ready = !fifo_full`, so a push never happens while the FIFO is full.
- Issue condition: FIFO not empty, `!stall_in`, and neither rs1 nor rs2 is busy in the scoreboard. r0 is never busy.
- On issue:
  - Pop the FIFO head.
  - Register the operands, `imm`, and `control_out`.
  - Pulse `enable_ex`.
  - Set the scoreboard bit for rd, unless rd == 0 or opcode is OP_STORE (4'hF) or OP_NOP (4'hE).
- When the issue condition is false: `enable_ex` = 0; `src1`, `src2`, `imm` and `control_out` hold their last values.
- Writeback: `wb_en` with `wb_addr` != 0 writes the register file and clears that scoreboard bit. Writeback to r0 is ignored.
- Set and clear on the same bit in the same cycle: set wins. The new pending write is the younger one.
- `imm` is always imm16 sign-extended to DATA_W; decode does not interpret the opcode further.
- Reset, including mid-operation: FIFO flushed, scoreboard cleared, register file zeroed, all outputs driven to 0. In-flight results that arrive on the writeback port after reset still write the register file.

## Timing
- Reset values: `enable_ex` 0, `src1` 0, `src2` 0, `imm` 0, `control_out` 0, `busy` 0, `instr_ready` 1.
- Latency: a word accepted at edge N issues at edge N+1 at the earliest. `enable_ex` is high during cycle N+1.
- Throughput: one issue per cycle when there are no hazards and no stall.
- FIFO full with a simultaneous pop: `instr_ready` reflects the registered full flag. No combinational ready-on-pop path.
- `stall_in` is sampled combinationally in the issue decision. An issue never occurs in a cycle with `stall_in` = 1.

## Configuration
- `DECODE_BYPASS_EN` defined:
  - A writeback in the same cycle as an operand read forwards `wb_data` into `src1`/`src2`.
  - The scoreboard clear is visible to that cycle's issue check.
  - A dependent instruction issues in the same cycle its producer's writeback arrives.
- `DECODE_BYPASS_EN` undefined:
  - Register file read-before-write.
  - The scoreboard clear takes effect the next cycle.
  - A dependent instruction issues one cycle after the writeback.

## Structure
- Package `decode_pkg` holds:
  - opcode enum, including OP_STORE = 4'hF and OP_NOP = 4'hE
  - field bit-position localparams
  - CTRL_W = 7
  - a decoded-instruction struct {opcode, rd, rs1, rs2, imm16}
- Sub-module `sync_fifo` (parameterized width and depth; registered full/empty flags) holds the instruction buffer. Register file, scoreboard, and issue logic stay in `instr_decode_issue`.

## Test plan
- Reset then idle: all outputs 0, `instr_ready` = 1, `busy` = 0; assert `reset` low mid-stream and confirm the FIFO flushes and `enable_ex` drops immediately.
- Single issue: push opcode 4'h1, rd 2, rs1 0, rs2 0, imm16 16'hFFFE. Expect `enable_ex` the next cycle, `imm` = 32'hFFFFFFFE, `control_out` = 7'b010_0001, scoreboard r2 set.
- RAW hazard: issue a write to r3, then a read of rs1 = r3. The second instruction holds until `wb_en`, `wb_addr` 3, `wb_data` 32'h1234 arrives. It then issues with `src1` = 32'h1234: same cycle with the macro, one cycle later without.
- Back-pressure: hold `stall_in` = 1 and push 5 words. `instr_ready` drops after 4. Release the stall and expect 4 consecutive issues in order, then the fifth.
- Store and r0: a store with rd 5 issues and sets no scoreboard bit; `wb_en` to r0 with 32'hDEAD leaves r0 reading 0.
- Same-cycle set and clear: writeback to r4 in the same cycle a new instruction with rd 4 issues. r4 remains busy afterwards.

Source files
------------

// File: rtl/decode_pkg.sv
// -----------------------------------------------------------------------------
// decode_pkg
// Shared definitions for the decode/issue stage: opcode encoding, instruction
// field positions, control-word width and the decoded-instruction record that
// travels through the instruction buffer.
// -----------------------------------------------------------------------------
package decode_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 4;
    localparam int REG_W   = 3;
    localparam int IMM_W   = 16;
    localparam int CTRL_W  = 7;   // {rd, opcode}

    // Field positions inside the 32-bit instruction word; [18:16] is reserved.
    localparam int OPC_LSB = 28;
    localparam int RD_LSB  = 25;
    localparam int RS1_LSB = 22;
    localparam int RS2_LSB = 19;
    localparam int RSV_LSB = 16;
    localparam int RSV_W   = 3;
    localparam int IMM_LSB = 0;

    typedef enum logic [OPC_W-1:0] {
        OP_ADD   = 4'h0,
        OP_SUB   = 4'h1,
        OP_AND   = 4'h2,
        OP_OR    = 4'h3,
        OP_XOR   = 4'h4,
        OP_SLL   = 4'h5,
        OP_SRL   = 4'h6,
        OP_LOAD  = 4'h7,
        OP_NOP   = 4'hE,
        OP_STORE = 4'hF
    } opcode_e;

    typedef struct packed {
        opcode_e              opcode;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rs1;
        logic [REG_W-1:0]     rs2;
        logic [IMM_W-1:0]     imm16;
    } dec_instr_t;

    // An issued instruction reserves rd only when it really produces a result.
    function automatic logic writes_rd(input opcode_e op, input logic [REG_W-1:0] rd);
        return (rd != '0) && (op != OP_STORE) && (op != OP_NOP);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with registered full/empty flags. Storage is not reset;
// only the pointers, count and flags are, so reset flushes the contents.
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset
//   push_i  : write data_i (ignored while full)
//   data_i  : write data
//   pop_i   : drop the head entry (ignored while empty)
//   data_o  : head entry (valid while !empty_o)
//   full_o  : registered full flag
//   empty_o : registered empty flag
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             full_q, empty_q;
    logic             push_ok, pop_ok;

    assign push_ok = push_i && !full_q;
    assign pop_ok  = pop_i && !empty_q;

    always_comb begin
        count_d = count_q + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
    end

    // Flags are computed from the next count so they are plain registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == (AW+1)'(DEPTH));
            empty_q <= (count_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/instr_decode_issue.sv
// -----------------------------------------------------------------------------
// instr_decode_issue
// Buffers instruction words, reads operands from an 8-entry register file and
// issues one decoded instruction per cycle to the execute stage. A scoreboard
// of pending writes holds issue on read-after-write hazards until the result
// comes back on the writeback port.
//
// Build option: DECODE_BYPASS_EN
//   defined   - writeback data forwards into src1/src2 and the scoreboard clear
//               is seen by the same cycle's issue check.
//   undefined - register file is read-before-write; the clear is seen a cycle
//               later.
//
// Ports:
//   clock, reset        : rising-edge clock, asynchronous active-low reset
//   instr_valid/ready   : instruction handshake (ready = FIFO not full)
//   instr               : 32-bit instruction word
//   stall_in            : execute stage cannot accept an issue this cycle
//   wb_en/addr/data     : result writeback from execute
//   enable_ex           : one-cycle pulse per issued instruction
//   src1, src2, imm     : registered operands and sign-extended immediate
//   control_out         : {rd, opcode}
//   busy                : FIFO non-empty or any write pending
// -----------------------------------------------------------------------------
module instr_decode_issue
    import decode_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_AW     = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    input  logic              stall_in,
    input  logic              wb_en,
    input  logic [REG_AW-1:0] wb_addr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              enable_ex,
    output logic [DATA_W-1:0] src1,
    output logic [DATA_W-1:0] src2,
    output logic [DATA_W-1:0] imm,
    output logic [CTRL_W-1:0] control_out,
    output logic              busy
);

    localparam int NREGS = 2 ** REG_AW;
    localparam int DEC_W = $bits(dec_instr_t);

    dec_instr_t        in_dec, head;
    logic [DEC_W-1:0]  fifo_rdata;
    logic              fifo_full, fifo_empty, push, issue;
    logic [NREGS-1:0]  sb_q, sb_d, sb_view, clr_mask, set_mask;
    logic [DATA_W-1:0] rf_q [NREGS];
    logic [DATA_W-1:0] op1, op2, imm_ext;
    logic              wb_live;

    logic              enable_ex_q;
    logic [DATA_W-1:0] src1_q, src2_q, imm_q;
    logic [CTRL_W-1:0] ctrl_q;

    // Reserved field [18:16] carries no meaning for decode.
    logic unused_rsvd;
    assign unused_rsvd = ^instr[RSV_LSB +: RSV_W];

    always_comb begin
        in_dec.opcode = opcode_e'(instr[OPC_LSB +: OPC_W]);
        in_dec.rd     = instr[RD_LSB  +: REG_W];
        in_dec.rs1    = instr[RS1_LSB +: REG_W];
        in_dec.rs2    = instr[RS2_LSB +: REG_W];
        in_dec.imm16  = instr[IMM_LSB +: IMM_W];
    end

    assign instr_ready = !fifo_full;
    assign push        = instr_valid && !fifo_full;

    sync_fifo #(
        .WIDTH (DEC_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clock),
        .rst_ni  (reset),
        .push_i  (push),
        .data_i  (in_dec),
        .pop_i   (issue),
        .data_o  (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head    = dec_instr_t'(fifo_rdata);
    assign wb_live = wb_en && (wb_addr != '0);

    always_comb begin
        clr_mask = '0;
        if (wb_live) clr_mask[wb_addr] = 1'b1;

`ifdef DECODE_BYPASS_EN
        sb_view = sb_q & ~clr_mask;
`else
        sb_view = sb_q;
`endif

        issue = !fifo_empty && !stall_in && !sb_view[head.rs1] && !sb_view[head.rs2];

        set_mask = '0;
        if (issue && writes_rd(head.opcode, head.rd)) set_mask[head.rd] = 1'b1;

        // Set after clear: the newly issued write is the younger one.
        sb_d = (sb_q & ~clr_mask) | set_mask;

        op1 = rf_q[head.rs1];
        op2 = rf_q[head.rs2];
`ifdef DECODE_BYPASS_EN
        if (wb_live && (wb_addr == head.rs1)) op1 = wb_data;
        if (wb_live && (wb_addr == head.rs2)) op2 = wb_data;
`endif

        imm_ext = {{(DATA_W-IMM_W){head.imm16[IMM_W-1]}}, head.imm16};
    end

    // r0 is never written, so it keeps its reset value of zero.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NREGS; i++) rf_q[i] <= '0;
        end else if (wb_live) begin
            rf_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sb_q        <= '0;
            enable_ex_q <= 1'b0;
            src1_q      <= '0;
            src2_q      <= '0;
            imm_q       <= '0;
            ctrl_q      <= '0;
        end else begin
            sb_q        <= sb_d;
            enable_ex_q <= issue;
            if (issue) begin
                src1_q <= op1;
                src2_q <= op2;
                imm_q  <= imm_ext;
                ctrl_q <= {head.rd, head.opcode};
            end
        end
    end

    assign enable_ex   = enable_ex_q;
    assign src1        = src1_q;
    assign src2        = src2_q;
    assign imm         = imm_q;
    assign control_out = ctrl_q;
    assign busy        = !fifo_empty || (|sb_q);

endmodule

// File: tb/tb_instr_decode_issue.sv
module tb_instr_decode_issue;

    localparam int DATA_W     = 32;
    localparam int REG_AW     = 3;
    localparam int FIFO_DEPTH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              instr_valid = 1'b0;
    logic              instr_ready;
    logic [31:0]       instr = '0;
    logic              stall_in = 1'b0;
    logic              wb_en = 1'b0;
    logic [REG_AW-1:0] wb_addr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              enable_ex;
    logic [DATA_W-1:0] src1, src2, imm;
    logic [6:0]        control_out;
    logic              busy;

    always #5 clock = ~clock;

    instr_decode_issue #(
        .DATA_W     (DATA_W),
        .REG_AW     (REG_AW),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .stall_in    (stall_in),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .enable_ex   (enable_ex),
        .src1        (src1),
        .src2        (src2),
        .imm         (imm),
        .control_out (control_out),
        .busy        (busy)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: instruction queue, register values, pending-write flags.
    logic [31:0] mq[$];
    logic [31:0] regs [8];
    bit   [7:0]  pend;
    logic        m_en, m_busy, m_ready;
    logic [31:0] m_src1, m_src2, m_imm;
    logic [6:0]  m_ctrl;

    typedef struct {
        string       name;
        logic [31:0] word;
        logic [31:0] exp_imm;
        logic [6:0]  exp_ctrl;
        logic        exp_busy;
    } vec_t;

    vec_t vecs[7];

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [2:0] rd,
                                       input logic [2:0] rs1, input logic [2:0] rs2,
                                       input logic [15:0] imm16, input logic [2:0] rsv);
        return {op, rd, rs1, rs2, rsv, imm16};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int i = 0; i < 8; i++) regs[i] = '0;
        pend    = '0;
        m_en    = 1'b0;
        m_src1  = '0;
        m_src2  = '0;
        m_imm   = '0;
        m_ctrl  = '0;
        m_busy  = 1'b0;
        m_ready = 1'b1;
    endtask

    function automatic logic [31:0] operand(input int r);
        if (r == 0) return '0;
`ifdef DECODE_BYPASS_EN
        if (wb_en && int'(wb_addr) == r) return wb_data;
`endif
        return regs[r];
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit          acc, iss;
        bit   [7:0]  pv;
        logic [31:0] h;
        int          r1, r2, rd;
        acc = instr_valid && (mq.size() < FIFO_DEPTH);
        pv  = pend;
`ifdef DECODE_BYPASS_EN
        if (wb_en && wb_addr != 0) pv[wb_addr] = 1'b0;
`endif
        iss = 1'b0;
        h   = '0;
        if (mq.size() > 0 && !stall_in) begin
            h   = mq[0];
            r1  = int'(h[24:22]);
            r2  = int'(h[21:19]);
            iss = !pv[r1] && !pv[r2];
        end
        if (iss) begin
            m_src1 = operand(int'(h[24:22]));
            m_src2 = operand(int'(h[21:19]));
            m_imm  = 32'($signed(h[15:0]));
            m_ctrl = {h[27:25], h[31:28]};
            mq.delete(0);
        end
        m_en = iss;
        if (wb_en && wb_addr != 0) begin
            regs[wb_addr] = wb_data;
            pend[wb_addr] = 1'b0;
        end
        if (iss) begin
            rd = int'(h[27:25]);
            if (rd != 0 && h[31:28] != 4'hF && h[31:28] != 4'hE) pend[rd] = 1'b1;
        end
        if (acc) mq.push_back(instr);
        m_busy  = (mq.size() != 0) || (pend != 0);
        m_ready = (mq.size() < FIFO_DEPTH);
    endtask

    task automatic check_all();
        chk("enable_ex",   32'(enable_ex),   32'(m_en));
        chk("src1",        src1,             m_src1);
        chk("src2",        src2,             m_src2);
        chk("imm",         imm,              m_imm);
        chk("control_out", 32'(control_out), 32'(m_ctrl));
        chk("busy",        32'(busy),        32'(m_busy));
        chk("instr_ready", 32'(instr_ready), 32'(m_ready));
    endtask

    task automatic cycle();
        model_step();
        @(posedge clock);
        #1;
        check_all();
    endtask

    task automatic idle_inputs();
        instr_valid = 1'b0;
        stall_in    = 1'b0;
        wb_en       = 1'b0;
        wb_addr     = '0;
        wb_data     = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        vecs[0] = '{"single", mk(4'h1, 3'd2, 3'd0, 3'd0, 16'hFFFE, 3'd0), 32'hFFFF_FFFE, 7'b010_0001, 1'b1};
        vecs[1] = '{"store",  mk(4'hF, 3'd5, 3'd0, 3'd0, 16'h0010, 3'd0), 32'h0000_0010, 7'b101_1111, 1'b0};
        vecs[2] = '{"nop",    mk(4'hE, 3'd3, 3'd0, 3'd0, 16'h0000, 3'd0), 32'h0000_0000, 7'b011_1110, 1'b0};
        vecs[3] = '{"rd0",    mk(4'h2, 3'd0, 3'd0, 3'd0, 16'h7FFF, 3'd0), 32'h0000_7FFF, 7'b000_0010, 1'b0};
        vecs[4] = '{"negmin", mk(4'h3, 3'd7, 3'd0, 3'd0, 16'h8000, 3'd0), 32'hFFFF_8000, 7'b111_0011, 1'b1};
        vecs[5] = '{"rsvd",   mk(4'h4, 3'd1, 3'd0, 3'd0, 16'h1234, 3'd7), 32'h0000_1234, 7'b001_0100, 1'b1};
        vecs[6] = '{"opD",    mk(4'hD, 3'd6, 3'd0, 3'd0, 16'hFFFF, 3'd0), 32'hFFFF_FFFF, 7'b110_1101, 1'b1};

        // Reset values while reset is held.
        idle_inputs();
        repeat (3) @(posedge clock);
        #1;
        chk("rst_enable_ex",   32'(enable_ex),   32'd0);
        chk("rst_src1",        src1,             32'd0);
        chk("rst_src2",        src2,             32'd0);
        chk("rst_imm",         imm,              32'd0);
        chk("rst_control_out", 32'(control_out), 32'd0);
        chk("rst_busy",        32'(busy),        32'd0);
        chk("rst_instr_ready", 32'(instr_ready), 32'd1);
        reset = 1'b1;
        model_reset();
        repeat (3) cycle();

        // Table of single issues from an idle, freshly reset DUT.
        for (int v = 0; v < 7; v++) begin
            do_reset();
            instr_valid = 1'b1;
            instr       = vecs[v].word;
            cycle();
            chk({vecs[v].name, "_no_early_issue"}, 32'(enable_ex), 32'd0);
            instr_valid = 1'b0;
            cycle();
            chk({vecs[v].name, "_enable_ex"}, 32'(enable_ex),   32'd1);
            chk({vecs[v].name, "_imm"},       imm,              vecs[v].exp_imm);
            chk({vecs[v].name, "_ctrl"},      32'(control_out), 32'(vecs[v].exp_ctrl));
            chk({vecs[v].name, "_busy"},      32'(busy),        32'(vecs[v].exp_busy));
            cycle();
            chk({vecs[v].name, "_pulse_ends"}, 32'(enable_ex), 32'd0);
        end

        // RAW hazard on r3.
        do_reset();
        instr_valid = 1'b1;
        instr = mk(4'h1, 3'd3, 3'd0, 3'd0, 16'h0001, 3'd0);
        cycle();
        instr = mk(4'h2, 3'd1, 3'd3, 3'd0, 16'h0002, 3'd0);
        cycle();
        chk("raw_producer_issue", 32'(enable_ex), 32'd1);
        instr_valid = 1'b0;
        cycle();
        cycle();
        chk("raw_consumer_held", 32'(enable_ex), 32'd0);
        wb_en = 1'b1; wb_addr = 3'd3; wb_data = 32'h0000_1234;
        cycle();
        wb_en = 1'b0;
`ifdef DECODE_BYPASS_EN
        chk("raw_bypass_issue", 32'(enable_ex), 32'd1);
        chk("raw_bypass_src1",  src1,           32'h0000_1234);
        cycle();
`else
        chk("raw_wb_cycle_held", 32'(enable_ex), 32'd0);
        cycle();
        chk("raw_late_issue", 32'(enable_ex), 32'd1);
        chk("raw_late_src1",  src1,           32'h0000_1234);
`endif

        // Back-pressure: five pushes under stall, then drain in order.
        do_reset();
        stall_in    = 1'b1;
        instr_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk("bp_ready_before_push", 32'(instr_ready), 32'd1);
            instr = mk(4'(k), 3'(k + 1), 3'd0, 3'd0, 16'(k), 3'd0);
            cycle();
        end
        chk("bp_ready_full", 32'(instr_ready), 32'd0);
        instr = mk(4'h4, 3'd5, 3'd0, 3'd0, 16'h0004, 3'd0);
        cycle();
        cycle();
        chk("bp_stalled_no_issue", 32'(enable_ex),   32'd0);
        chk("bp_still_full",       32'(instr_ready), 32'd0);
        stall_in = 1'b0;
        for (int k = 0; k < 5; k++) begin
            cycle();
            if (k == 1) instr_valid = 1'b0;
            chk("bp_drain_issue", 32'(enable_ex), 32'd1);
            chk("bp_drain_order", imm,            32'(k));
        end
        cycle();
        chk("bp_drained", 32'(enable_ex), 32'd0);

        // Store sets no pending bit; writeback to r0 is ignored.
        do_reset();
        instr_valid = 1'b1;
        instr = mk(4'hF, 3'd5, 3'd0, 3'd0, 16'h0000, 3'd0);
        cycle();
        instr_valid = 1'b0;
        cycle();
        chk("store_issue", 32'(enable_ex), 32'd1);
        chk("store_busy",  32'(busy),      32'd0);
        wb_en = 1'b1; wb_addr = 3'd0; wb_data = 32'h0000_DEAD;
        cycle();
        wb_en = 1'b0;
        instr_valid = 1'b1;
        instr = mk(4'h1, 3'd0, 3'd0, 3'd0, 16'h0000, 3'd0);
        cycle();
        instr_valid = 1'b0;
        cycle();
        chk("r0_reads_zero", src1, 32'd0);

        // Same-cycle set and clear on r4: the set wins.
        do_reset();
        instr_valid = 1'b1;
        instr = mk(4'h1, 3'd4, 3'd0, 3'd0, 16'h0000, 3'd0);
        cycle();
        instr = mk(4'h2, 3'd4, 3'd0, 3'd0, 16'h0001, 3'd0);
        cycle();
        instr_valid = 1'b0;
        wb_en = 1'b1; wb_addr = 3'd4; wb_data = 32'h0000_0055;
        cycle();
        wb_en = 1'b0;
        chk("setclr_issue", 32'(enable_ex), 32'd1);
        chk("setclr_busy",  32'(busy),      32'd1);
        instr_valid = 1'b1;
        instr = mk(4'h3, 3'd1, 3'd4, 3'd0, 16'h0002, 3'd0);
        cycle();
        instr_valid = 1'b0;
        cycle();
        chk("setclr_r4_still_pending", 32'(enable_ex), 32'd0);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            int plist[$];
            instr_valid = ($urandom_range(0, 99) < 60);
            instr       = $urandom();
            stall_in    = ($urandom_range(0, 99) < 25);
            wb_en       = ($urandom_range(0, 99) < 35);
            wb_data     = $urandom();
            for (int i = 1; i < 8; i++) if (pend[i]) plist.push_back(i);
            if (plist.size() > 0 && $urandom_range(0, 3) != 0)
                wb_addr = 3'(plist[$urandom_range(0, plist.size() - 1)]);
            else
                wb_addr = 3'($urandom_range(0, 7));
            cycle();
        end

        // Mid-stream reset, then a late writeback still lands in the register file.
        do_reset();
        instr_valid = 1'b1;
        instr = mk(4'h1, 3'd0, 3'd0, 3'd0, 16'h0007, 3'd0);
        repeat (3) cycle();
        chk("mid_pre_issue", 32'(enable_ex), 32'd1);
        reset = 1'b0;
        #1;
        chk("mid_enable_ex_drop", 32'(enable_ex),   32'd0);
        chk("mid_busy",           32'(busy),        32'd0);
        chk("mid_ready",          32'(instr_ready), 32'd1);
        chk("mid_imm",            imm,              32'd0);
        chk("mid_control_out",    32'(control_out), 32'd0);
        model_reset();
        idle_inputs();
        #2;
        reset = 1'b1;
        cycle();
        chk("mid_flushed", 32'(enable_ex), 32'd0);
        wb_en = 1'b1; wb_addr = 3'd6; wb_data = 32'hCAFE_F00D;
        cycle();
        wb_en = 1'b0;
        instr_valid = 1'b1;
        instr = mk(4'h1, 3'd0, 3'd6, 3'd6, 16'h0000, 3'd0);
        cycle();
        instr_valid = 1'b0;
        cycle();
        chk("late_wb_src1", src1, 32'hCAFE_F00D);
        chk("late_wb_src2", src2, 32'hCAFE_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
